// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous ROM read port between two burst
// requesters. Bursts are granted round-robin, addresses wrap at DEPTH-1,
// and returned words are steered to the owner with valid/last strobes.
module rom_arbiter #(
    parameter int DEPTH = 100,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_i,
    input  logic          req1_i,
    input  logic [AW-1:0] start0_i,
    input  logic [AW-1:0] start1_i,
    input  logic [AW-1:0] len0_i,
    input  logic [AW-1:0] len1_i,
    output logic          ack0_o,
    output logic          ack1_o,
    output logic          err0_o,
    output logic          err1_o,
    output logic          rvalid0_o,
    output logic          rvalid1_o,
    output logic          rlast0_o,
    output logic          rlast1_o,
    output logic [DW-1:0] rdata0_o,
    output logic [DW-1:0] rdata1_o,
    output logic          rom_en_o,
    output logic [AW-1:0] rom_addr_o,
    input  logic [DW-1:0] rom_data_i,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DRAIN
    } state_e;

    // Highest legal address / length value; also the wrap point.
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;   // requester that owns the current burst
    logic          rr_q, rr_d;         // requester favoured when both ask
    logic [AW-1:0] addr_q, addr_d;     // next ROM address to issue
    logic [AW-1:0] rem_q, rem_d;       // words left to issue after this one
    logic [1:0]    ack_q, ack_d;
    logic [1:0]    err_q, err_d;
    logic          rvalid_q, rvalid_d; // rom_en delayed to match ROM latency
    logic          rlast_q, rlast_d;

    logic          can_accept;
    logic          any_req;
    logic          gsel;
    logic [AW-1:0] sel_start;
    logic [AW-1:0] sel_len;
    logic          sel_bad;

    // Pick the candidate requester and decide whether its request is legal.
    always_comb begin
        can_accept = (state_q == S_IDLE) || (state_q == S_DRAIN);
        any_req    = req0_i | req1_i;
        if (req0_i && req1_i) begin
            gsel = rr_q;
        end else begin
            gsel = req1_i;
        end
        sel_start = gsel ? start1_i : start0_i;
        sel_len   = gsel ? len1_i   : len0_i;
        sel_bad   = (sel_start > LAST) || (sel_len > LAST);
    end

    // Next-state logic for the burst sequencer and its response strobes.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        ack_d    = '0;
        err_d    = '0;
        rvalid_d = (state_q == S_BURST);
        rlast_d  = (state_q == S_BURST) && (rem_q == '0);

        case (state_q)
            S_BURST: begin
                if (rem_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = (addr_q == LAST) ? '0 : addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                end
            end
            S_IDLE, S_DRAIN: begin
                // The final word returns during DRAIN, so a new request can be
                // taken on the edge that ends it.
                state_d = S_IDLE;
                if (can_accept && any_req) begin
                    ack_d[gsel] = 1'b1;
                    if (sel_bad) begin
                        err_d[gsel] = 1'b1;
                    end else begin
                        state_d = S_BURST;
                        owner_d = gsel;
                        addr_d  = sel_start;
                        rem_d   = sel_len;
                        rr_d    = ~gsel;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and strobe registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            rr_q     <= 1'b0;
            addr_q   <= '0;
            rem_q    <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
        end
    end

    assign busy_o     = (state_q == S_BURST) || (state_q == S_DRAIN);
    assign rom_en_o   = (state_q == S_BURST);
    assign rom_addr_o = rom_en_o ? addr_q : '0;

    assign ack0_o = ack_q[0];
    assign ack1_o = ack_q[1];
    assign err0_o = err_q[0];
    assign err1_o = err_q[1];

    // Returned words go only to the owner; the other side stays quiet.
    assign rvalid0_o = rvalid_q & ~owner_q;
    assign rvalid1_o = rvalid_q &  owner_q;
    assign rlast0_o  = rlast_q  & ~owner_q;
    assign rlast1_o  = rlast_q  &  owner_q;
    assign rdata0_o  = rvalid0_o ? rom_data_i : '0;
    assign rdata1_o  = rvalid1_o ? rom_data_i : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a transaction-level schedule model predicts every
// output for every cycle; directed bursts add literal expectations.
module tb_rom_arbiter;

    localparam int DEPTH = 100;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int MAXC  = 8192;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1;
    logic [AW-1:0] start0, start1, len0, len1;
    logic          ack0, ack1, err0, err1;
    logic          rvalid0, rvalid1, rlast0, rlast1;
    logic [DW-1:0] rdata0, rdata1;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          busy;

    rom_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_i     (req0),
        .req1_i     (req1),
        .start0_i   (start0),
        .start1_i   (start1),
        .len0_i     (len0),
        .len1_i     (len1),
        .ack0_o     (ack0),
        .ack1_o     (ack1),
        .err0_o     (err0),
        .err1_o     (err1),
        .rvalid0_o  (rvalid0),
        .rvalid1_o  (rvalid1),
        .rlast0_o   (rlast0),
        .rlast1_o   (rlast1),
        .rdata0_o   (rdata0),
        .rdata1_o   (rdata1),
        .rom_en_o   (rom_en),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: word appears one cycle after the enabled read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- schedule model ----------------
    // Interval k is the clock period that follows rising edge k. A grant at
    // edge n fills in the expected outputs for the whole burst in advance.
    bit            e_ack [2][MAXC];
    bit            e_err [2][MAXC];
    bit            e_rv  [2][MAXC];
    bit            e_rl  [2][MAXC];
    logic [DW-1:0] e_dat [2][MAXC];
    bit            e_en  [MAXC];
    bit            e_busy[MAXC];
    int            e_addr[MAXC];
    int            free_at = 0;   // earliest edge that may accept a request
    bit            m_ptr   = 1'b0;

    task automatic model_step(input int n);
        bit g;
        int st, ln, a;
        if (n < free_at) return;
        if (!req0 && !req1) return;
        g  = (req0 && req1) ? m_ptr : req1;
        st = g ? int'(start1) : int'(start0);
        ln = g ? int'(len1)   : int'(len0);
        e_ack[g][n] = 1'b1;
        if (st >= DEPTH || ln >= DEPTH) begin
            e_err[g][n] = 1'b1;
            free_at = n + 1;
        end else begin
            for (int i = 0; i <= ln; i++) begin
                a = (st + i) % DEPTH;
                if (n + i + 1 < MAXC) begin
                    e_en[n + i]       = 1'b1;
                    e_addr[n + i]     = a;
                    e_busy[n + i]     = 1'b1;
                    e_rv[g][n + 1 + i]  = 1'b1;
                    e_dat[g][n + 1 + i] = mem[a];
                end
            end
            if (n + ln + 1 < MAXC) begin
                e_rl[g][n + ln + 1] = 1'b1;
                e_busy[n + ln + 1]  = 1'b1;
            end
            m_ptr   = !g;
            free_at = n + ln + 2;
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n === 1'b1) model_step(cyc);
    end

    // Reset wipes everything scheduled from the current interval onward.
    always @(negedge rst_n) begin
        for (int k = cyc; k < MAXC; k++) begin
            for (int r = 0; r < 2; r++) begin
                e_ack[r][k] = 1'b0;
                e_err[r][k] = 1'b0;
                e_rv[r][k]  = 1'b0;
                e_rl[r][k]  = 1'b0;
                e_dat[r][k] = '0;
            end
            e_en[k]   = 1'b0;
            e_busy[k] = 1'b0;
            e_addr[k] = 0;
        end
        free_at = 0;
        m_ptr   = 1'b0;
    end

    // Compare every output against the schedule, mid-period.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            check("ctrl",
                  {ack0, err0, ack1, err1, rom_en, busy, rvalid0, rlast0, rvalid1, rlast1},
                  {e_ack[0][cyc], e_err[0][cyc], e_ack[1][cyc], e_err[1][cyc], e_en[cyc],
                   e_busy[cyc], e_rv[0][cyc], e_rl[0][cyc], e_rv[1][cyc], e_rl[1][cyc]});
            check("rdata0", rdata0, e_dat[0][cyc]);
            check("rdata1", rdata1, e_dat[1][cyc]);
            if (e_en[cyc] || !rst_n) check("rom_addr", rom_addr, e_addr[cyc][AW-1:0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int who, input bit r, input int st, input int ln);
        if (who == 0) begin
            req0 = r; start0 = AW'(st); len0 = AW'(ln);
        end else begin
            req1 = r; start1 = AW'(st); len1 = AW'(ln);
        end
    endtask

    task automatic wait_ack(input int who, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((who == 0 && ack0) || (who == 1 && ack1)) begin
                ok = 1'b1;
                break;
            end
        end
        check("ack_within_budget", ok, 1'b1);
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    // Directed burst with literal expectations for address and data order.
    task automatic lit_burst(input int who, input int st, input int ln, input int addrs[$]);
        bit ok;
        logic [AW-1:0] ea;
        set_req(who, 1'b1, st, ln);
        wait_ack(who, 300, ok);
        set_req(who, 1'b0, 0, 0);
        if (!ok) return;
        check("lit_ack", {ack0, ack1, err0, err1, busy}, (who == 0) ? 5'b10001 : 5'b01001);
        for (int i = 0; i <= ln + 1; i++) begin
            if (i <= ln) begin
                ea = AW'(addrs[i]);
                check("lit_rom", {rom_en, rom_addr}, {1'b1, ea});
            end else begin
                check("lit_drain_en", rom_en, 1'b0);
            end
            if (i >= 1) begin
                ea = AW'(addrs[i - 1]);
                if (who == 0) begin
                    check("lit_rv0", {rvalid0, rlast0, rvalid1}, {1'b1, (i - 1 == ln), 1'b0});
                    check("lit_rdata0", rdata0, mem[ea]);
                end else begin
                    check("lit_rv1", {rvalid1, rlast1, rvalid0}, {1'b1, (i - 1 == ln), 1'b0});
                    check("lit_rdata1", rdata1, mem[ea]);
                end
            end
            tick();
        end
        check("lit_after", {busy, rom_en, rvalid0, rvalid1}, 4'b0000);
    endtask

    task automatic new_random_req(input int who);
        int st, ln, r;
        st = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 255) : $urandom_range(0, DEPTH - 1);
        r  = $urandom_range(0, 19);
        if (r == 0)      ln = $urandom_range(DEPTH, 255);
        else if (r == 1) ln = $urandom_range(0, DEPTH - 1);
        else             ln = $urandom_range(0, 7);
        set_req(who, 1'b1, st, ln);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int q[$];
        int who_q[$];
        int at_q[$];
        bit ok;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
        rst_n = 1'b0;
        set_req(0, 1'b0, 0, 0);
        set_req(1, 1'b0, 0, 0);
        repeat (3) tick();
        check("reset_outputs",
              {ack0, ack1, err0, err1, rvalid0, rvalid1, rlast0, rlast1, rom_en, busy},
              10'b0);
        check("reset_addr_data", {rom_addr, rdata0, rdata1}, '0);
        rst_n = 1'b1;
        tick();

        // Single burst.
        q.delete(); q.push_back(5); q.push_back(6); q.push_back(7); q.push_back(8);
        lit_burst(0, 5, 3, q);

        // Wrap at DEPTH-1.
        q.delete(); q.push_back(98); q.push_back(99); q.push_back(0); q.push_back(1);
        lit_burst(1, 98, 3, q);

        // Illegal start, then a legal request from the other side.
        set_req(0, 1'b1, 100, 0);
        wait_ack(0, 20, ok);
        set_req(0, 1'b0, 0, 0);
        if (ok) check("illegal_resp", {ack0, err0, ack1, busy, rom_en}, 5'b11000);
        q.delete(); q.push_back(10); q.push_back(11);
        lit_burst(1, 10, 1, q);

        // Full length.
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(i);
        lit_burst(0, 0, 99, q);

        // Contention from reset with single-word bursts.
        rst_n = 1'b0;
        set_req(0, 1'b1, 3, 0);
        set_req(1, 1'b1, 7, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40 && who_q.size() < 4; i++) begin
            tick();
            if (ack0) begin who_q.push_back(0); at_q.push_back(cyc); end
            if (ack1) begin who_q.push_back(1); at_q.push_back(cyc); end
        end
        set_req(0, 1'b0, 0, 0);
        set_req(1, 1'b0, 0, 0);
        check("contention_count", who_q.size(), 4);
        if (who_q.size() >= 4) begin
            check("contention_order", {who_q[0][0], who_q[1][0], who_q[2][0], who_q[3][0]}, 4'b0101);
            for (int i = 1; i < 4; i++) check("contention_gap", at_q[i] - at_q[i - 1], 2);
        end
        repeat (4) tick();

        // Reset during the third word of a 10-word burst.
        set_req(0, 1'b1, 20, 9);
        wait_ack(0, 20, ok);
        set_req(0, 1'b0, 0, 0);
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_clear",
              {rom_en, rvalid0, rvalid1, rlast0, rlast1, busy, ack0, ack1}, 8'b0);
        set_req(1, 1'b1, 50, 2);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_ack(1, 20, ok);
        set_req(1, 1'b0, 0, 0);
        if (ok) check("post_reset_grant", {ack1, ack0, err1}, 3'b100);
        repeat (6) tick();

        // Randomized traffic from both requesters, with one async reset.
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (c == 2000) begin
                #1;
                apply_reset(2);
            end
            if (req0 && ack0) begin
                set_req(0, 1'b0, 0, 0);
                if ($urandom_range(0, 2) == 0) new_random_req(0);
            end else if (!req0 && $urandom_range(0, 3) == 0) begin
                new_random_req(0);
            end
            if (req1 && ack1) begin
                set_req(1, 1'b0, 0, 0);
                if ($urandom_range(0, 2) == 0) new_random_req(1);
            end else if (!req1 && $urandom_range(0, 3) == 0) begin
                new_random_req(1);
            end
        end
        set_req(0, 1'b0, 0, 0);
        set_req(1, 1'b0, 0, 0);
        repeat (120) tick();
        check("final_idle", {busy, rom_en}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
